hist_seq_ctrl: RTL and testbench
================================

Name: hist_seq_ctrl

Overview:
Frame-level sequencer for the gray-histogram equalisation pipeline (bin collector, CDF engine, remap LUT).
- On each accepted end-of-frame, runs three sequential 256-entry phases: bin LOAD into the CDF engine, LUT UPDATE, bin CLEAN.
- Gates the pixel input while bin memory is owned by the sequencer.
- Holds the Avalon-MM config/status register bank; shadows config into active values at frame boundaries.

Parameters:
BINS, 256, histogram entries; phase length in cycles
ADDR_W, 8, bin/LUT address width (log2 BINS)
CDF_LAT, 4, cycles from last load to first valid CDF output
W, 960, reset frame width
H, 540, reset frame height

Ports:
clk  in  1  clock
rst  in  1  async active-high reset
avs_s0_address  in  2  register select
avs_s0_write  in  1  register write strobe
avs_s0_writedata  in  32  write data
avs_s0_read  in  1  register read strobe
avs_s0_readdata  out  32  read data, registered, 1-cycle latency
sink_eop  in  1  1-cycle end-of-frame pulse from frame counter
sink_valid  in  1  pixel valid from upstream
src_ready  in  1  downstream ready
sink_ready  out  1  pixel accept to upstream
load  out  1  bin read strobe to CDF engine
update  out  1  LUT write strobe
clean  out  1  bin clear strobe
seq_addr  out  ADDR_W  shared address for load/update/clean
bypass  out  1  active bypass
width  out  16  active width
height  out  16  active height
busy  out  1  state != IDLE
irq  out  1  frame-done interrupt (optional feature)

Behaviour:
- Reset values: all strobes 0, seq_addr 0, busy 0, readdata 0, irq 0, bypass 0, width W, height H. Shadow regs take the same values. Overrun flag 0, frame counter 0.
- Registers:
  - addr0 CTRL rw: bit0 bypass_s, bit1 enable_s (reset 1).
  - addr1 SIZE rw: [31:16] width_s, [15:0] height_s.
  - addr2 STATUS: bit0 busy (ro), bit1 overrun (sticky, write-1-clear), [31:16] frames_done (ro, wraps at 0xFFFF).
  - addr3 IRQ: see Optional Feature; reads 0 when the feature is absent.
- Accepted eop: sink_eop=1 while state==IDLE.
  - Same cycle edge: active bypass/width/height <= shadows.
  - If enable_s=1 and bypass_s=0 (value being shadowed), state -> LOAD; otherwise stay IDLE.
- Shadow write in the same cycle as an accepted eop: the active value takes the old shadow; the new value applies at the next eop.
- sink_eop while state!=IDLE: overrun <= 1; eop ignored; actives unchanged.
- FSM, seq_addr counter shared across phases and reset to 0 on each phase entry:
  - IDLE -> LOAD on accepted eop.
  - LOAD: load=1 for BINS cycles, addr 0..BINS-1. After addr BINS-1 -> WAIT.
  - WAIT: CDF_LAT cycles, all strobes 0 -> UPDATE.
  - UPDATE: update=1 for BINS cycles, addr 0..BINS-1 -> CLEAN.
  - CLEAN: clean=1 for BINS cycles, addr 0..BINS-1 -> IDLE. frames_done increments on the last CLEAN cycle.
  - Total busy duration: 3*BINS+CDF_LAT cycles.
- Strobes and seq_addr are registered. At most one strobe is high in any cycle.
- sink_ready = src_ready & !(state==LOAD | state==CLEAN). This is combinational; pixels accumulate only when bins are not owned by the sequencer.
- Reset mid-operation: immediate return to IDLE with all reset values. The next frame reprocesses from scratch.
- avs read and write to the same address in one cycle: readdata returns the pre-write value.

Optional Feature:
Macro HIST_SEQ_IRQ_EN.
- With the macro:
  - addr3 bit0 pending: set on the last CLEAN cycle; write-1-clear. If set and clear coincide, set wins.
  - addr3 bit1 mask: rw, reset 0.
  - irq = pending & mask, registered.
- Without the macro: irq tied 0, addr3 reads 0, writes to addr3 are ignored.

Decomposition:
- Package hist_pkg: the state enum (IDLE, LOAD, WAIT, UPDATE, CLEAN), register address constants, CTRL/STATUS bit positions, BINS/ADDR_W defaults.
- One sub-module, hist_seq_regs: Avalon register bank, shadows, sticky flags, IRQ.
- FSM and counter stay in the top module.

Test Plan:
- Reset, then read addr1 -> 0x03C0021C; read addr0 -> 0x2; busy=0.
- eop with enable=1, bypass=0 -> load high for 256 cycles with addr 0..255, then 4 idle cycles, 256 update, 256 clean. Busy for 772 cycles; frames_done=1.
- Write SIZE=0x07800438 then eop -> width=1920 and height=1080 from the cycle after eop.
- Write SIZE in the same cycle as eop -> active values unchanged until the second eop.
- eop during UPDATE -> STATUS bit1=1 and the phase sequence is unaffected. Write 0x2 to addr2 -> bit1 clears.
- src_ready=1 throughout -> sink_ready=0 during LOAD and CLEAN and 1 in IDLE/WAIT/UPDATE. Reset asserted mid-UPDATE -> strobes 0 at once, state IDLE.
- With HIST_SEQ_IRQ_EN and mask=1: irq rises 1 cycle after the last CLEAN cycle. Writing 1 to addr3 bit0 drops irq.

Source files
------------

// File: rtl/hist_pkg.sv
// hist_pkg: shared types and constants for the histogram-equalisation frame sequencer.
// Holds the sequencer state enum, register addresses and register bit positions.
package hist_pkg;
    localparam int BINS_DEF    = 256;
    localparam int ADDR_W_DEF  = 8;
    localparam int CDF_LAT_DEF = 4;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, UPDATE, CLEAN} state_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_SIZE   = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_IRQ    = 2'd3;

    localparam int CTRL_BYPASS = 0;
    localparam int CTRL_EN     = 1;
    localparam int ST_BUSY     = 0;
    localparam int ST_OVR      = 1;
    localparam int IRQ_PEND    = 0;
    localparam int IRQ_MASK    = 1;
endpackage

// File: rtl/hist_seq_ctrl_if.sv
// hist_seq_ctrl_if: Avalon-MM slave register port of the histogram sequencer.
// Signals: avs_s0_address/write/writedata/read (host -> sequencer), avs_s0_readdata (sequencer -> host).
interface hist_seq_ctrl_if;
    logic [1:0]  avs_s0_address;
    logic        avs_s0_write;
    logic [31:0] avs_s0_writedata;
    logic        avs_s0_read;
    logic [31:0] avs_s0_readdata;

    modport master (output avs_s0_address, avs_s0_write, avs_s0_writedata, avs_s0_read,
                    input  avs_s0_readdata);
    modport slave  (input  avs_s0_address, avs_s0_write, avs_s0_writedata, avs_s0_read,
                    output avs_s0_readdata);
endinterface

// File: rtl/hist_seq_regs.sv
// hist_seq_regs: config/status register bank, shadow-to-active transfer at frame boundaries, sticky flags.
// Ports: clk, rst (async, active-high); avs (Avalon slave); eop, busy, done from the sequencer;
// bypass/width/height active values; go = shadowed frame processing enabled; irq.
// Optional: HIST_SEQ_IRQ_EN adds the pending/mask interrupt register at addr3.
module hist_seq_regs
    import hist_pkg::*;
#(
    parameter logic [15:0] W = 16'd960,
    parameter logic [15:0] H = 16'd540
) (
    input  logic             clk,
    input  logic             rst,
    hist_seq_ctrl_if.slave   avs,
    input  logic             eop,
    input  logic             busy,
    input  logic             done,
    output logic             bypass,
    output logic [15:0]      width,
    output logic [15:0]      height,
    output logic             go,
    output logic             irq
);
    logic        bypass_s, enable_s, overrun;
    logic [15:0] width_s, height_s, frames;
    logic [31:0] irq_rd, rdata;
    logic        wr_ctrl, wr_size, wr_stat, wr_irq;

    assign wr_ctrl = avs.avs_s0_write && avs.avs_s0_address == A_CTRL;
    assign wr_size = avs.avs_s0_write && avs.avs_s0_address == A_SIZE;
    assign wr_stat = avs.avs_s0_write && avs.avs_s0_address == A_STATUS;
    assign wr_irq  = avs.avs_s0_write && avs.avs_s0_address == A_IRQ;
    assign go      = enable_s && !bypass_s;

    always_comb begin
        rdata = avs.avs_s0_address == A_CTRL   ? {30'd0, enable_s, bypass_s} :
                avs.avs_s0_address == A_SIZE   ? {width_s, height_s} :
                avs.avs_s0_address == A_STATUS ? {frames, 14'd0, overrun, busy} : irq_rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bypass_s            <= 1'b0;
            enable_s            <= 1'b1;
            width_s             <= W;
            height_s            <= H;
            bypass              <= 1'b0;
            width               <= W;
            height              <= H;
            overrun             <= 1'b0;
            frames              <= 16'd0;
            avs.avs_s0_readdata <= 32'd0;
        end else begin
            if (wr_ctrl) begin
                bypass_s <= avs.avs_s0_writedata[CTRL_BYPASS];
                enable_s <= avs.avs_s0_writedata[CTRL_EN];
            end
            if (wr_size) begin
                width_s  <= avs.avs_s0_writedata[31:16];
                height_s <= avs.avs_s0_writedata[15:0];
            end
            // Actives take the pre-write shadows when a write coincides with the eop.
            if (eop && !busy) begin
                bypass <= bypass_s;
                width  <= width_s;
                height <= height_s;
            end
            overrun <= (eop && busy) || (overrun && !(wr_stat && avs.avs_s0_writedata[ST_OVR]));
            if (done)
                frames <= frames + 16'd1;
            if (avs.avs_s0_read)
                avs.avs_s0_readdata <= rdata;
        end
    end

`ifdef HIST_SEQ_IRQ_EN
    logic pend, mask, pend_n;

    // A new frame-done beats a simultaneous clear.
    assign pend_n = done || (pend && !(wr_irq && avs.avs_s0_writedata[IRQ_PEND]));
    assign irq_rd = {30'd0, mask, pend};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
            mask <= 1'b0;
            irq  <= 1'b0;
        end else begin
            pend <= pend_n;
            if (wr_irq)
                mask <= avs.avs_s0_writedata[IRQ_MASK];
            irq <= pend_n && mask;
        end
    end
`else
    logic unused_irq_wr;
    assign unused_irq_wr = wr_irq;
    assign irq_rd        = 32'd0;
    assign irq           = 1'b0;
`endif
endmodule

// File: rtl/hist_seq_ctrl.sv
// hist_seq_ctrl: per-frame LOAD / WAIT / UPDATE / CLEAN sequencer for histogram equalisation.
// Ports: clk, rst (async, active-high); avs (Avalon register slave); sink_eop, sink_valid, src_ready in;
// sink_ready, load/update/clean strobes, seq_addr, active bypass/width/height, busy, irq out.
// Optional: define HIST_SEQ_IRQ_EN for the frame-done interrupt.
module hist_seq_ctrl
    import hist_pkg::*;
#(
    parameter int          BINS    = BINS_DEF,
    parameter int          ADDR_W  = ADDR_W_DEF,
    parameter int          CDF_LAT = CDF_LAT_DEF,
    parameter logic [15:0] W       = 16'd960,
    parameter logic [15:0] H       = 16'd540
) (
    input  logic              clk,
    input  logic              rst,
    hist_seq_ctrl_if.slave    avs,
    input  logic              sink_eop,
    input  logic              sink_valid,
    input  logic              src_ready,
    output logic              sink_ready,
    output logic              load,
    output logic              update,
    output logic              clean,
    output logic [ADDR_W-1:0] seq_addr,
    output logic              bypass,
    output logic [15:0]       width,
    output logic [15:0]       height,
    output logic              busy,
    output logic              irq
);
    state_t            state, state_n;
    logic [ADDR_W-1:0] cnt_n;
    logic              go, last, lat_done, done;
    logic              unused_valid;

    assign unused_valid = sink_valid;
    assign last         = seq_addr == ADDR_W'(BINS - 1);
    assign lat_done     = seq_addr == ADDR_W'(CDF_LAT - 1);
    assign done         = state == CLEAN && last;
    assign busy         = state != IDLE;
    // Bins belong to the sequencer while they are read out or cleared.
    assign sink_ready   = src_ready && !(state == LOAD || state == CLEAN);

    always_comb begin
        state_n = state;
        cnt_n   = seq_addr + 1'b1;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (sink_eop && go)
                    state_n = LOAD;
            end
            LOAD:   if (last)     begin state_n = WAIT;   cnt_n = '0; end
            WAIT:   if (lat_done) begin state_n = UPDATE; cnt_n = '0; end
            UPDATE: if (last)     begin state_n = CLEAN;  cnt_n = '0; end
            CLEAN:  if (last)     begin state_n = IDLE;   cnt_n = '0; end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            seq_addr <= '0;
            load     <= 1'b0;
            update   <= 1'b0;
            clean    <= 1'b0;
        end else begin
            state    <= state_n;
            seq_addr <= cnt_n;
            load     <= state_n == LOAD;
            update   <= state_n == UPDATE;
            clean    <= state_n == CLEAN;
        end
    end

    hist_seq_regs #(.W(W), .H(H)) u_regs (
        .clk    (clk),
        .rst    (rst),
        .avs    (avs),
        .eop    (sink_eop),
        .busy   (busy),
        .done   (done),
        .bypass (bypass),
        .width  (width),
        .height (height),
        .go     (go),
        .irq    (irq)
    );
endmodule

// File: tb/tb_hist_seq_ctrl.sv
// tb_hist_seq_ctrl: directed self-checking bench for the histogram frame sequencer.
module tb_hist_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sink_eop = 1'b0;
    logic        sink_valid = 1'b1;
    logic        src_ready = 1'b1;
    logic        sink_ready, load, update, clean, bypass, busy, irq;
    logic [7:0]  seq_addr;
    logic [15:0] width, height;
    logic [31:0] rd_val;
    int          tests = 0;
    int          fails = 0;

    hist_seq_ctrl_if avs();

    hist_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .avs        (avs),
        .sink_eop   (sink_eop),
        .sink_valid (sink_valid),
        .src_ready  (src_ready),
        .sink_ready (sink_ready),
        .load       (load),
        .update     (update),
        .clean      (clean),
        .seq_addr   (seq_addr),
        .bypass     (bypass),
        .width      (width),
        .height     (height),
        .busy       (busy),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        avs.avs_s0_address = a;
        avs.avs_s0_read    = 1'b1;
        tick();
        avs.avs_s0_read    = 1'b0;
        d = avs.avs_s0_readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs.avs_s0_address   = a;
        avs.avs_s0_writedata = d;
        avs.avs_s0_write     = 1'b1;
        tick();
        avs.avs_s0_write     = 1'b0;
    endtask

    task automatic pulse_eop;
        sink_eop = 1'b1;
        tick();
        sink_eop = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        avs.avs_s0_address = 2'd0;
        avs.avs_s0_write = 1'b0;
        avs.avs_s0_read = 1'b0;
        avs.avs_s0_writedata = 32'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        tests++;
        if ({load, update, clean, busy, bypass, irq, sink_ready} !== 7'b0000001) begin
            fails++;
            $display("FAIL reset_flags got %b exp %b", {load, update, clean, busy, bypass, irq, sink_ready}, 7'b0000001);
        end
        tests++;
        if ({seq_addr, width, height, avs.avs_s0_readdata} !== {8'd0, 16'd960, 16'd540, 32'd0}) begin
            fails++;
            $display("FAIL reset_values addr=%0d w=%0d h=%0d rd=%h", seq_addr, width, height, avs.avs_s0_readdata);
        end
        rd(2'd1, rd_val);
        tests++;
        if (rd_val !== 32'h03C0021C) begin
            fails++;
            $display("FAIL reset_size got %h exp 03c0021c", rd_val);
        end
        rd(2'd0, rd_val);
        tests++;
        if (rd_val !== 32'h2) begin
            fails++;
            $display("FAIL reset_ctrl got %h exp 00000002", rd_val);
        end
        rd(2'd2, rd_val);
        tests++;
        if (rd_val !== 32'h0) begin
            fails++;
            $display("FAIL reset_status got %h exp 00000000", rd_val);
        end
    endtask

    // Runs one full frame from an accepted eop; optionally fires a second eop at cycle eop_at.
    task automatic test_frame(input int eop_at, input logic [31:0] exp_status);
        logic [12:0] got, exp;
        logic [7:0]  ea;
        pulse_eop();
        for (int c = 0; c < 772; c++) begin
            ea  = c < 256 ? 8'(c) : c < 260 ? 8'(c - 256) : c < 516 ? 8'(c - 260) : 8'(c - 516);
            exp = {c < 256, c >= 260 && c < 516, c >= 516, 1'b1, !(c < 256 || c >= 516), ea};
            got = {load, update, clean, busy, sink_ready, seq_addr};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL frame_cycle c=%0d got %h exp %h", c, got, exp);
            end
            if (c == eop_at)
                sink_eop = 1'b1;
            tick();
            sink_eop = 1'b0;
        end
        tests++;
        if ({load, update, clean, busy, sink_ready} !== 5'b00001) begin
            fails++;
            $display("FAIL frame_end got %b exp 00001", {load, update, clean, busy, sink_ready});
        end
        rd(2'd2, rd_val);
        tests++;
        if (rd_val !== exp_status) begin
            fails++;
            $display("FAIL frame_status got %h exp %h", rd_val, exp_status);
        end
    endtask

    task automatic test_size;
        wr(2'd0, 32'h0);
        wr(2'd1, 32'h07800438);
        tests++;
        if ({width, height} !== {16'd960, 16'd540}) begin
            fails++;
            $display("FAIL size_shadow_only got %0d x %0d exp 960 x 540", width, height);
        end
        pulse_eop();
        tests++;
        if ({width, height, busy} !== {16'd1920, 16'd1080, 1'b0}) begin
            fails++;
            $display("FAIL size_applied got %0d x %0d busy=%b exp 1920 x 1080 busy=0", width, height, busy);
        end
        avs.avs_s0_address   = 2'd1;
        avs.avs_s0_writedata = 32'h01000080;
        avs.avs_s0_write     = 1'b1;
        sink_eop             = 1'b1;
        tick();
        avs.avs_s0_write     = 1'b0;
        sink_eop             = 1'b0;
        tests++;
        if ({width, height} !== {16'd1920, 16'd1080}) begin
            fails++;
            $display("FAIL size_same_cycle got %0d x %0d exp 1920 x 1080", width, height);
        end
        pulse_eop();
        tests++;
        if ({width, height} !== {16'd256, 16'd128}) begin
            fails++;
            $display("FAIL size_second_eop got %0d x %0d exp 256 x 128", width, height);
        end
        wr(2'd0, 32'h3);
        pulse_eop();
        tests++;
        if ({bypass, busy} !== 2'b10) begin
            fails++;
            $display("FAIL bypass_no_run got bypass=%b busy=%b exp bypass=1 busy=0", bypass, busy);
        end
    endtask

    task automatic test_overrun;
        wr(2'd0, 32'h2);
        test_frame(300, 32'h00020002);
        tests++;
        if (bypass !== 1'b0) begin
            fails++;
            $display("FAIL overrun_bypass got %b exp 0", bypass);
        end
        wr(2'd2, 32'h2);
        rd(2'd2, rd_val);
        tests++;
        if (rd_val !== 32'h00020000) begin
            fails++;
            $display("FAIL overrun_clear got %h exp 00020000", rd_val);
        end
    endtask

    task automatic test_rw_same;
        avs.avs_s0_address   = 2'd0;
        avs.avs_s0_writedata = 32'h3;
        avs.avs_s0_write     = 1'b1;
        avs.avs_s0_read      = 1'b1;
        tick();
        avs.avs_s0_write     = 1'b0;
        avs.avs_s0_read      = 1'b0;
        tests++;
        if (avs.avs_s0_readdata !== 32'h2) begin
            fails++;
            $display("FAIL rw_same_old got %h exp 00000002", avs.avs_s0_readdata);
        end
        rd(2'd0, rd_val);
        tests++;
        if (rd_val !== 32'h3) begin
            fails++;
            $display("FAIL rw_same_new got %h exp 00000003", rd_val);
        end
        wr(2'd0, 32'h2);
    endtask

    task automatic test_reset_mid;
        wr(2'd1, 32'h01000080);
        pulse_eop();
        repeat (300) tick();
        tests++;
        if (update !== 1'b1) begin
            fails++;
            $display("FAIL mid_in_update got %b exp 1", update);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({load, update, clean, busy, seq_addr, width, height} !== {4'b0, 8'd0, 16'd960, 16'd540}) begin
            fails++;
            $display("FAIL mid_reset got l=%b u=%b c=%b busy=%b addr=%0d w=%0d h=%0d", load, update, clean, busy, seq_addr, width, height);
        end
        tick();
        rst = 1'b0;
        tick();
        rd(2'd2, rd_val);
        tests++;
        if (rd_val !== 32'h0) begin
            fails++;
            $display("FAIL mid_status got %h exp 00000000", rd_val);
        end
        rd(2'd1, rd_val);
        tests++;
        if (rd_val !== 32'h03C0021C) begin
            fails++;
            $display("FAIL mid_size got %h exp 03c0021c", rd_val);
        end
        test_frame(-1, 32'h00010000);
    endtask

    task automatic test_irq;
`ifdef HIST_SEQ_IRQ_EN
        int early = 0;
        wr(2'd3, 32'h2);
        pulse_eop();
        for (int c = 0; c < 772; c++) begin
            if (irq !== 1'b0)
                early++;
            tick();
        end
        tests++;
        if (early != 0) begin
            fails++;
            $display("FAIL irq_early got %0d high cycles exp 0", early);
        end
        tests++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL irq_rise got %b exp 1", irq);
        end
        rd(2'd3, rd_val);
        tests++;
        if (rd_val !== 32'h3) begin
            fails++;
            $display("FAIL irq_reg got %h exp 00000003", rd_val);
        end
        wr(2'd3, 32'h3);
        tests++;
        if (irq !== 1'b0) begin
            fails++;
            $display("FAIL irq_clear got %b exp 0", irq);
        end
        rd(2'd3, rd_val);
        tests++;
        if (rd_val !== 32'h2) begin
            fails++;
            $display("FAIL irq_reg_clear got %h exp 00000002", rd_val);
        end
`else
        wr(2'd3, 32'h3);
        rd(2'd3, rd_val);
        tests++;
        if ({rd_val, irq} !== 33'd0) begin
            fails++;
            $display("FAIL irq_absent got rd=%h irq=%b exp 0", rd_val, irq);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_frame(-1, 32'h00010000);
        test_size();
        test_overrun();
        test_rw_same();
        test_reset_mid();
        test_irq();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
